// File: rtl/cmd_pkg.sv
// cmd_pkg: opcode constants, opcode width, fetch FSM state encoding and legality check
package cmd_pkg;
  localparam int OP_W = 3;
  localparam logic [OP_W-1:0] NUL_CMD = 3'b000;
  localparam logic [OP_W-1:0] JMP_CMD = 3'b001;
  localparam logic [OP_W-1:0] SJF_CMD = 3'b010;
  localparam logic [OP_W-1:0] SJB_CMD = 3'b100;
  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
  function automatic logic is_legal(input logic [OP_W-1:0] op);
    return op inside {NUL_CMD, JMP_CMD, SJF_CMD, SJB_CMD};
  endfunction
endpackage

// File: rtl/cmd_fetch_if.sv
// cmd_fetch_if: pointer input, memory read bus and decoded command output of cmd_fetch
//   master = cmd_fetch side: drives mem_req/mem_addr and cmd_valid/opcode/addr_to/illegal/fetch_err
//   slave  = environment side: drives addr_point/point_ready, mem_ack/mem_rdata and cmd_ready
interface cmd_fetch_if #(parameter int BUS_WIDTH = 32);
  import cmd_pkg::*;
  logic [BUS_WIDTH-1:0] addr_point;
  logic                 point_ready;
  logic                 mem_req;
  logic [BUS_WIDTH-1:0] mem_addr;
  logic                 mem_ack;
  logic [BUS_WIDTH-1:0] mem_rdata;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [OP_W-1:0]      opcode;
  logic [BUS_WIDTH-1:0] addr_to;
  logic                 illegal;
  logic                 fetch_err;
  modport master(
    input  addr_point, point_ready, mem_ack, mem_rdata, cmd_ready,
    output mem_req, mem_addr, cmd_valid, opcode, addr_to, illegal, fetch_err
  );
  modport slave(
    output addr_point, point_ready, mem_ack, mem_rdata, cmd_ready,
    input  mem_req, mem_addr, cmd_valid, opcode, addr_to, illegal, fetch_err
  );
endinterface

// File: rtl/cmd_timeout.sv
// cmd_timeout: counts cycles while en is high, clears when en drops; expire flags the LIMIT-th cycle
//   ports: clk, nreset (async, active-low), en, expire
module cmd_timeout #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic nreset,
  input  logic en,
  output logic expire
);
  localparam int CW = $clog2(LIMIT + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) cnt <= '0;
    else         cnt <= en ? cnt + 1'b1 : '0;
  assign expire = en && cnt == CW'(LIMIT - 1);
endmodule

// File: rtl/cmd_fetch.sv
// cmd_fetch: fetches one instruction word per pointer address and decodes it into opcode/addr_to
//   ports: clk, nreset (async, active-low), bus (cmd_fetch_if.master: pointer in, memory read, command out)
//   optional CMD_FETCH_TIMEOUT_EN: abandon a read after TIMEOUT_CYCLES in REQ, emit NUL_CMD and set sticky fetch_err
module cmd_fetch import cmd_pkg::*; #(
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic         clk,
  input logic         nreset,
  cmd_fetch_if.master bus
);
  if (BUS_WIDTH < 8 || TIMEOUT_CYCLES < 2) begin : g_cfg_check
    $error("cmd_fetch: BUS_WIDTH must be >= 8 and TIMEOUT_CYCLES >= 2");
  end
  state_t               state, state_n;
  logic                 req, req_n, valid, valid_n, ill, ill_n, expire, legal;
  logic [BUS_WIDTH-1:0] addr, addr_n, to, to_n, raw_to;
  logic [OP_W-1:0]      op, op_n, raw_op;
  assign raw_op = bus.mem_rdata[BUS_WIDTH-1 -: OP_W];
  assign raw_to = {{OP_W{1'b0}}, bus.mem_rdata[BUS_WIDTH-OP_W-1:0]};
  assign legal  = is_legal(raw_op);
`ifdef CMD_FETCH_TIMEOUT_EN
  logic err;
  cmd_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk    (clk),
    .nreset (nreset),
    .en     (state == REQ),
    .expire (expire)
  );
  // mem_ack arriving on the limit cycle takes priority, so only a genuine miss sets the flag
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) err <= 1'b0;
    else         err <= err | (state == REQ && !bus.mem_ack && expire);
  assign bus.fetch_err = err;
`else
  assign expire        = 1'b0;
  assign bus.fetch_err = 1'b0;
`endif
  always_comb begin
    state_n = state;
    req_n   = req;
    addr_n  = addr;
    valid_n = valid;
    op_n    = op;
    to_n    = to;
    ill_n   = 1'b0;
    case (state)
      IDLE: if (bus.point_ready) begin
        state_n = REQ;
        req_n   = 1'b1;
        addr_n  = bus.addr_point;
      end
      REQ: if (bus.mem_ack) begin
        state_n = HOLD;
        req_n   = 1'b0;
        valid_n = 1'b1;
        op_n    = legal ? raw_op : NUL_CMD;
        to_n    = legal ? raw_to : '0;
        ill_n   = !legal;
      end else if (expire) begin
        state_n = HOLD;
        req_n   = 1'b0;
        valid_n = 1'b1;
        op_n    = NUL_CMD;
        to_n    = '0;
      end
      HOLD: if (bus.cmd_ready) begin
        state_n = IDLE;
        valid_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      state <= IDLE;
      req   <= 1'b0;
      addr  <= '0;
      valid <= 1'b0;
      op    <= NUL_CMD;
      to    <= '0;
      ill   <= 1'b0;
    end else begin
      state <= state_n;
      req   <= req_n;
      addr  <= addr_n;
      valid <= valid_n;
      op    <= op_n;
      to    <= to_n;
      ill   <= ill_n;
    end
  assign bus.mem_req   = req;
  assign bus.mem_addr  = addr;
  assign bus.cmd_valid = valid;
  assign bus.opcode    = op;
  assign bus.addr_to   = to;
  assign bus.illegal   = ill;
endmodule

// File: tb/tb_cmd_fetch.sv
// tb_cmd_fetch: directed self-checking bench for cmd_fetch
module tb_cmd_fetch;
  import cmd_pkg::*;
  localparam int W = 32;
  logic clk = 1'b0;
  logic nreset = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  cmd_fetch_if #(.BUS_WIDTH(W)) bus();
  cmd_fetch #(.BUS_WIDTH(W), .TIMEOUT_CYCLES(4)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus.master)
  );
  function automatic logic [70:0] outs();
    return {bus.mem_req, bus.mem_addr, bus.cmd_valid, bus.opcode, bus.addr_to, bus.illegal, bus.fetch_err};
  endfunction
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic fetch(input logic [W-1:0] a, input logic [W-1:0] d);
    bus.point_ready = 1'b1;
    bus.addr_point  = a;
    step();
    bus.point_ready = 1'b0;
    bus.mem_ack     = 1'b1;
    bus.mem_rdata   = d;
    step();
    bus.mem_ack     = 1'b0;
  endtask
  task automatic release_cmd();
    bus.cmd_ready = 1'b1;
    step();
    bus.cmd_ready = 1'b0;
  endtask
  task automatic test_reset();
    step();
    n_checks++; if (outs() !== 71'h0) begin n_fail++; $display("FAIL reset_outs: got %h want %h", outs(), 71'h0); end
    bus.point_ready = 1'b1;
    bus.addr_point  = 32'h10;
    step(2);
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_hold_req: got %b want 0", bus.mem_req); end
  endtask
  task automatic test_basic();
    nreset = 1'b1;
    step();
    n_checks++; if ({bus.mem_req, bus.mem_addr, bus.cmd_valid} !== {1'b1, 32'h10, 1'b0}) begin n_fail++; $display("FAIL basic_req: got %h want %h", {bus.mem_req, bus.mem_addr, bus.cmd_valid}, {1'b1, 32'h10, 1'b0}); end
    bus.point_ready = 1'b0;
    bus.mem_ack     = 1'b1;
    bus.mem_rdata   = 32'h2000_0005;
    step();
    bus.mem_ack = 1'b0;
    n_checks++; if ({bus.cmd_valid, bus.opcode, bus.addr_to, bus.illegal, bus.mem_req} !== {1'b1, JMP_CMD, 32'h5, 1'b0, 1'b0}) begin n_fail++; $display("FAIL basic_cmd: got %h want %h", {bus.cmd_valid, bus.opcode, bus.addr_to, bus.illegal, bus.mem_req}, {1'b1, JMP_CMD, 32'h5, 1'b0, 1'b0}); end
    release_cmd();
    n_checks++; if (bus.cmd_valid !== 1'b0) begin n_fail++; $display("FAIL basic_release: got %b want 0", bus.cmd_valid); end
  endtask
  task automatic test_backpressure();
    fetch(32'h20, 32'h4000_00AB);
    bus.point_ready = 1'b1;
    bus.addr_point  = 32'h30;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if ({bus.cmd_valid, bus.opcode, bus.addr_to, bus.mem_req} !== {1'b1, SJF_CMD, 32'hAB, 1'b0}) begin n_fail++; $display("FAIL backpressure_hold%0d: got %h want %h", i, {bus.cmd_valid, bus.opcode, bus.addr_to, bus.mem_req}, {1'b1, SJF_CMD, 32'hAB, 1'b0}); end
      step();
    end
    bus.point_ready = 1'b0;
    release_cmd();
    n_checks++; if ({bus.cmd_valid, bus.mem_req} !== 2'b00) begin n_fail++; $display("FAIL backpressure_release: got %b want 00", {bus.cmd_valid, bus.mem_req}); end
  endtask
  task automatic test_illegal();
    fetch(32'h50, 32'hE000_0001);
    n_checks++; if ({bus.cmd_valid, bus.opcode, bus.addr_to, bus.illegal} !== {1'b1, NUL_CMD, 32'h0, 1'b1}) begin n_fail++; $display("FAIL illegal_decode: got %h want %h", {bus.cmd_valid, bus.opcode, bus.addr_to, bus.illegal}, {1'b1, NUL_CMD, 32'h0, 1'b1}); end
    step();
    n_checks++; if ({bus.cmd_valid, bus.illegal} !== 2'b10) begin n_fail++; $display("FAIL illegal_pulse: got %b want 10", {bus.cmd_valid, bus.illegal}); end
    release_cmd();
  endtask
  task automatic test_back_to_back();
    bus.cmd_ready   = 1'b1;
    bus.point_ready = 1'b1;
    bus.addr_point  = 32'h60;
    step();
    n_checks++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h60}) begin n_fail++; $display("FAIL b2b_req1: got %h want %h", {bus.mem_req, bus.mem_addr}, {1'b1, 32'h60}); end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h8000_1234;
    step();
    bus.mem_ack    = 1'b0;
    bus.addr_point = 32'h64;
    n_checks++; if ({bus.cmd_valid, bus.opcode, bus.addr_to, bus.mem_req} !== {1'b1, SJB_CMD, 32'h1234, 1'b0}) begin n_fail++; $display("FAIL b2b_cmd1: got %h want %h", {bus.cmd_valid, bus.opcode, bus.addr_to, bus.mem_req}, {1'b1, SJB_CMD, 32'h1234, 1'b0}); end
    step();
    n_checks++; if ({bus.cmd_valid, bus.mem_req} !== 2'b00) begin n_fail++; $display("FAIL b2b_idle: got %b want 00", {bus.cmd_valid, bus.mem_req}); end
    step();
    n_checks++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h64}) begin n_fail++; $display("FAIL b2b_req2: got %h want %h", {bus.mem_req, bus.mem_addr}, {1'b1, 32'h64}); end
    bus.point_ready = 1'b0;
    bus.mem_ack     = 1'b1;
    bus.mem_rdata   = 32'h0000_0003;
    step();
    bus.mem_ack = 1'b0;
    n_checks++; if ({bus.cmd_valid, bus.opcode, bus.addr_to, bus.illegal} !== {1'b1, NUL_CMD, 32'h3, 1'b0}) begin n_fail++; $display("FAIL b2b_cmd2: got %h want %h", {bus.cmd_valid, bus.opcode, bus.addr_to, bus.illegal}, {1'b1, NUL_CMD, 32'h3, 1'b0}); end
    step();
    bus.cmd_ready = 1'b0;
    n_checks++; if (bus.cmd_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_done: got %b want 0", bus.cmd_valid); end
  endtask
  task automatic test_slow_mem();
    bus.point_ready = 1'b1;
    bus.addr_point  = 32'h40;
    step();
    for (int i = 0; i < 3; i++) begin
      bus.addr_point = 32'h44 + 32'(4 * i);
      n_checks++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h40}) begin n_fail++; $display("FAIL slow_hold%0d: got %h want %h", i, {bus.mem_req, bus.mem_addr}, {1'b1, 32'h40}); end
      step();
    end
    bus.point_ready = 1'b0;
    bus.mem_ack     = 1'b1;
    bus.mem_rdata   = 32'h2000_0100;
    step();
    bus.mem_ack = 1'b0;
    n_checks++; if ({bus.cmd_valid, bus.opcode, bus.addr_to} !== {1'b1, JMP_CMD, 32'h100}) begin n_fail++; $display("FAIL slow_cmd: got %h want %h", {bus.cmd_valid, bus.opcode, bus.addr_to}, {1'b1, JMP_CMD, 32'h100}); end
    release_cmd();
  endtask
  task automatic test_ack_outside();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h4000_0077;
    step();
    bus.mem_ack = 1'b0;
    n_checks++; if ({bus.cmd_valid, bus.opcode, bus.addr_to, bus.mem_req, bus.illegal} !== {1'b0, JMP_CMD, 32'h100, 1'b0, 1'b0}) begin n_fail++; $display("FAIL ack_idle: got %h want %h", {bus.cmd_valid, bus.opcode, bus.addr_to, bus.mem_req, bus.illegal}, {1'b0, JMP_CMD, 32'h100, 1'b0, 1'b0}); end
    fetch(32'h70, 32'h2000_0009);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h8000_0FFF;
    step();
    bus.mem_ack = 1'b0;
    n_checks++; if ({bus.cmd_valid, bus.opcode, bus.addr_to, bus.illegal} !== {1'b1, JMP_CMD, 32'h9, 1'b0}) begin n_fail++; $display("FAIL ack_hold: got %h want %h", {bus.cmd_valid, bus.opcode, bus.addr_to, bus.illegal}, {1'b1, JMP_CMD, 32'h9, 1'b0}); end
    release_cmd();
  endtask
`ifdef CMD_FETCH_TIMEOUT_EN
  task automatic test_ack_at_limit();
    bus.point_ready = 1'b1;
    bus.addr_point  = 32'h90;
    step();
    bus.point_ready = 1'b0;
    step(3);
    n_checks++; if ({bus.mem_req, bus.fetch_err} !== 2'b10) begin n_fail++; $display("FAIL limit_wait: got %b want 10", {bus.mem_req, bus.fetch_err}); end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h2000_0042;
    step();
    bus.mem_ack = 1'b0;
    n_checks++; if ({bus.cmd_valid, bus.opcode, bus.addr_to, bus.fetch_err} !== {1'b1, JMP_CMD, 32'h42, 1'b0}) begin n_fail++; $display("FAIL limit_ack_wins: got %h want %h", {bus.cmd_valid, bus.opcode, bus.addr_to, bus.fetch_err}, {1'b1, JMP_CMD, 32'h42, 1'b0}); end
    release_cmd();
  endtask
  task automatic test_timeout();
    bus.point_ready = 1'b1;
    bus.addr_point  = 32'h80;
    step();
    bus.point_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if ({bus.mem_req, bus.cmd_valid, bus.fetch_err} !== 3'b100) begin n_fail++; $display("FAIL timeout_wait%0d: got %b want 100", i, {bus.mem_req, bus.cmd_valid, bus.fetch_err}); end
    end
    step();
    n_checks++; if ({bus.mem_req, bus.cmd_valid, bus.opcode, bus.addr_to, bus.fetch_err} !== {1'b0, 1'b1, NUL_CMD, 32'h0, 1'b1}) begin n_fail++; $display("FAIL timeout_fire: got %h want %h", {bus.mem_req, bus.cmd_valid, bus.opcode, bus.addr_to, bus.fetch_err}, {1'b0, 1'b1, NUL_CMD, 32'h0, 1'b1}); end
    release_cmd();
    n_checks++; if ({bus.cmd_valid, bus.fetch_err} !== 2'b01) begin n_fail++; $display("FAIL timeout_sticky: got %b want 01", {bus.cmd_valid, bus.fetch_err}); end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h2000_0011;
    step();
    bus.mem_ack = 1'b0;
    n_checks++; if ({bus.cmd_valid, bus.mem_req, bus.opcode, bus.addr_to, bus.fetch_err} !== {1'b0, 1'b0, NUL_CMD, 32'h0, 1'b1}) begin n_fail++; $display("FAIL timeout_late_ack: got %h want %h", {bus.cmd_valid, bus.mem_req, bus.opcode, bus.addr_to, bus.fetch_err}, {1'b0, 1'b0, NUL_CMD, 32'h0, 1'b1}); end
  endtask
`else
  task automatic test_no_timeout();
    bus.point_ready = 1'b1;
    bus.addr_point  = 32'h80;
    step();
    bus.point_ready = 1'b0;
    step(20);
    n_checks++; if ({bus.mem_req, bus.mem_addr, bus.cmd_valid, bus.fetch_err} !== {1'b1, 32'h80, 1'b0, 1'b0}) begin n_fail++; $display("FAIL no_timeout_wait: got %h want %h", {bus.mem_req, bus.mem_addr, bus.cmd_valid, bus.fetch_err}, {1'b1, 32'h80, 1'b0, 1'b0}); end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h2000_0011;
    step();
    bus.mem_ack = 1'b0;
    n_checks++; if ({bus.cmd_valid, bus.opcode, bus.addr_to, bus.fetch_err} !== {1'b1, JMP_CMD, 32'h11, 1'b0}) begin n_fail++; $display("FAIL no_timeout_cmd: got %h want %h", {bus.cmd_valid, bus.opcode, bus.addr_to, bus.fetch_err}, {1'b1, JMP_CMD, 32'h11, 1'b0}); end
    release_cmd();
  endtask
`endif
  task automatic test_reset_mid();
    bus.point_ready = 1'b1;
    bus.addr_point  = 32'hA0;
    step();
    bus.point_ready = 1'b0;
    n_checks++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL midreq_start: got %b want 1", bus.mem_req); end
    #2 nreset = 1'b0;
    #1;
    n_checks++; if (outs() !== 71'h0) begin n_fail++; $display("FAIL midreq_reset: got %h want %h", outs(), 71'h0); end
    step();
    nreset        = 1'b1;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h2000_0001;
    step();
    bus.mem_ack = 1'b0;
    step(2);
    n_checks++; if ({bus.cmd_valid, bus.mem_req} !== 2'b00) begin n_fail++; $display("FAIL midreq_no_cmd: got %b want 00", {bus.cmd_valid, bus.mem_req}); end
    fetch(32'hB0, 32'h4000_0002);
    n_checks++; if (bus.cmd_valid !== 1'b1) begin n_fail++; $display("FAIL midhold_start: got %b want 1", bus.cmd_valid); end
    #2 nreset = 1'b0;
    #1;
    n_checks++; if (outs() !== 71'h0) begin n_fail++; $display("FAIL midhold_reset: got %h want %h", outs(), 71'h0); end
    #1 nreset = 1'b1;
    step();
    n_checks++; if (bus.cmd_valid !== 1'b0) begin n_fail++; $display("FAIL midhold_no_cmd: got %b want 0", bus.cmd_valid); end
    fetch(32'hC0, 32'h2000_0003);
    n_checks++; if ({bus.cmd_valid, bus.opcode, bus.addr_to} !== {1'b1, JMP_CMD, 32'h3}) begin n_fail++; $display("FAIL reset_refetch: got %h want %h", {bus.cmd_valid, bus.opcode, bus.addr_to}, {1'b1, JMP_CMD, 32'h3}); end
    release_cmd();
  endtask
  initial begin
    bus.addr_point  = '0;
    bus.point_ready = 1'b0;
    bus.mem_ack     = 1'b0;
    bus.mem_rdata   = '0;
    bus.cmd_ready   = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_illegal();
    test_back_to_back();
    test_slow_mem();
    test_ack_outside();
`ifdef CMD_FETCH_TIMEOUT_EN
    test_ack_at_limit();
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
